// File: rtl/sar_result_averager.sv
// sar_result_averager
// Captures finished SAR conversions (rising edge of out_flag), averages blocks
// of 2^LOG2_AVG samples with round-half-up, and presents each block average on
// a valid/ready port. A completed average that cannot be stored because the
// previous one is still pending is dropped and flagged by the sticky overrun.
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst           synchronous active-high reset
//   enable        1 = accumulate, 0 = discard partial block, hold acc at zero
//   out_flag      SAR conversion done (pulse or level, rising edge captured)
//   digital_out   8-bit SAR result, valid while out_flag = 1
//   avg_data      block average, stable while avg_valid = 1
//   avg_valid     average available
//   avg_ready     consumer accepts when avg_valid & avg_ready at a rising edge
//   sample_cnt    samples accumulated in the current block
//   overrun       sticky, set when a completed average was dropped
//   clear_overrun synchronous clear of overrun (a same-cycle drop wins)
module sar_result_averager #(
  parameter int LOG2_AVG = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       out_flag,
  input  logic [7:0] digital_out,
  output logic [7:0] avg_data,
  output logic       avg_valid,
  input  logic       avg_ready,
  output logic [4:0] sample_cnt,
  output logic       overrun,
  input  logic       clear_overrun
);

  localparam int SUM_W = 8 + LOG2_AVG;
  localparam int N     = 1 << LOG2_AVG;
  // N/2 is zero for single-sample blocks, so no rounding term in that case.
  localparam logic [SUM_W-1:0] ROUND = SUM_W'(N / 2);
  localparam logic [4:0]       LAST  = 5'(N - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_reg, state_next;
  logic             flag_d_reg;
  logic [SUM_W-1:0] acc_reg, acc_next;
  logic [4:0]       cnt_reg, cnt_next;
  logic [7:0]       avg_data_reg, avg_data_next;
  logic             avg_valid_reg, avg_valid_next;
  logic             overrun_reg, overrun_next;

  logic             capture;
  logic             is_final;
  logic             drop;
  logic [SUM_W-1:0] sum_round;
  logic [7:0]       avg_result;
  logic             unused_sum_parity;

  assign capture  = out_flag & ~flag_d_reg & enable;
  assign is_final = capture && (cnt_reg == LAST);

  // sum + N/2 < N*256, so the rounded sum always fits in SUM_W bits and the
  // shifted result is simply the top 8 bits.
  assign sum_round  = acc_reg + SUM_W'(digital_out) + ROUND;
  assign avg_result = sum_round[LOG2_AVG +: 8];
  assign unused_sum_parity = ^sum_round;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    avg_data_next  = avg_data_reg;
    avg_valid_next = avg_valid_reg;
    overrun_next   = overrun_reg;
    drop           = 1'b0;

    case (state_reg)
      IDLE: begin
        acc_next = '0;
        cnt_next = '0;
        if (enable) state_next = ACCUM;
      end
      ACCUM: begin
        if (!enable) begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    // capture implies enable, so it never conflicts with the clears above
    if (capture) begin
      if (is_final) begin
        acc_next = '0;
        cnt_next = '0;
      end else begin
        acc_next = acc_reg + SUM_W'(digital_out);
        cnt_next = cnt_reg + 5'd1;
      end
    end

    // A final capture may coincide with the consumer taking the old average;
    // then the slot frees and refills in the same edge.
    if (is_final) begin
      if (!avg_valid_reg || avg_ready) begin
        avg_data_next  = avg_result;
        avg_valid_next = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (avg_valid_reg && avg_ready) begin
      avg_valid_next = 1'b0;
    end

    if (drop)               overrun_next = 1'b1;
    else if (clear_overrun) overrun_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      flag_d_reg    <= 1'b1;  // a level already high at reset release is not a new conversion
      acc_reg       <= '0;
      cnt_reg       <= '0;
      avg_data_reg  <= '0;
      avg_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flag_d_reg    <= out_flag;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      avg_data_reg  <= avg_data_next;
      avg_valid_reg <= avg_valid_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign avg_data   = avg_data_reg;
  assign avg_valid  = avg_valid_reg;
  assign sample_cnt = cnt_reg;
  assign overrun    = overrun_reg;

endmodule
